// File: rtl/anton_neopixel_stream_receiver_pkg.sv
// anton_neopixel_stream_receiver_pkg: receiver state encoding and parameter defaults
package anton_neopixel_stream_receiver_pkg;
    localparam int BUFFER_END_DEFAULT = 63;
    localparam int RESET_DELAY_DEFAULT = 320;
    localparam int RX_ONE_THRESHOLD_DEFAULT = 4;
    localparam int RX_MAX_HIGH_DEFAULT = 7;
    typedef enum logic [1:0] {
        RX_WAIT_GAP = 2'd0,
        RX_IDLE     = 2'd1,
        RX_RECEIVE  = 2'd2,
        RX_FORWARD  = 2'd3
    } rxState_t;
endpackage

// File: rtl/anton_neopixel_pulse_meter.sv
// anton_neopixel_pulse_meter: synchronises the line and measures high pulse widths and low gaps
module anton_neopixel_pulse_meter
    import anton_neopixel_stream_receiver_pkg::*;
#(
    parameter int RESET_DELAY = RESET_DELAY_DEFAULT,
    parameter int ONE_THRESHOLD = RX_ONE_THRESHOLD_DEFAULT,
    parameter int MAX_HIGH = RX_MAX_HIGH_DEFAULT
) (
    input  logic clk6_4mhz,
    input  logic reset,
    input  logic streamIn,
    output logic lineSync,
    output logic lineRise,
    output logic bitStrobe,
    output logic bitValue,
    output logic bitError,
    output logic gapReached
);
    logic syncMeta, lineDly;
    logic [3:0] highCount;
    logic [11:0] lowCount;
    always_ff @(posedge clk6_4mhz or posedge reset) begin
        if (reset) begin
            syncMeta <= 1'b0;
            lineSync <= 1'b0;
            lineDly <= 1'b0;
            highCount <= '0;
            lowCount <= '0;
        end else begin
            syncMeta <= streamIn;
            lineSync <= syncMeta;
            lineDly <= lineSync;
            if (lineRise) highCount <= 4'd1;
            else if (lineSync && highCount != 4'hf) highCount <= highCount + 4'd1;
            if (lineSync) lowCount <= '0;
            else if (!gapReached) lowCount <= lowCount + 12'd1;
        end
    end
    assign lineRise = lineSync & ~lineDly;
    // highCount still holds the finished pulse width on the falling-edge cycle
    assign bitStrobe = ~lineSync & lineDly;
    assign bitValue = highCount >= 4'(ONE_THRESHOLD);
    assign bitError = highCount > 4'(MAX_HIGH);
    assign gapReached = lowCount == 12'(RESET_DELAY);
endmodule

// File: rtl/anton_neopixel_stream_receiver.sv
// anton_neopixel_stream_receiver: decodes a WS2812 line into 24-bit pixels with frame and error flags
module anton_neopixel_stream_receiver
    import anton_neopixel_stream_receiver_pkg::*;
#(
    parameter int BUFFER_END = BUFFER_END_DEFAULT,
    parameter int RESET_DELAY = RESET_DELAY_DEFAULT,
    parameter int ONE_THRESHOLD = RX_ONE_THRESHOLD_DEFAULT,
    parameter int MAX_HIGH = RX_MAX_HIGH_DEFAULT,
    localparam int BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
    input  logic clk6_4mhz,
    input  logic reset,
    input  logic regCtrlRun,
    input  logic regCtrlForward,
    input  logic streamIn,
    output logic streamForward,
    output logic [23:0] pixelData,
    output logic pixelValid,
    output logic [BUFFER_BITS-1:0] pixelIndex,
    output logic [BUFFER_BITS:0] pixelCount,
    output logic frameDone,
    output logic errHigh,
    output logic errPartial,
    output logic errOverflow
);
    localparam logic [BUFFER_BITS:0] LAST_INDEX = (BUFFER_BITS + 1)'(BUFFER_END);
    localparam logic [BUFFER_BITS:0] ONE_PIXEL = (BUFFER_BITS + 1)'(1);
    rxState_t state, nextState;
    logic lineSync, lineRise, bitStrobe, bitValue, bitError, gapReached;
    logic [23:0] shiftReg;
    logic [4:0] bitCount;
    logic pixelPending, frameEnd;
    logic [BUFFER_BITS:0] frameCount;
    anton_neopixel_pulse_meter #(
        .RESET_DELAY(RESET_DELAY),
        .ONE_THRESHOLD(ONE_THRESHOLD),
        .MAX_HIGH(MAX_HIGH)
    ) meter (
        .clk6_4mhz(clk6_4mhz),
        .reset(reset),
        .streamIn(streamIn),
        .lineSync(lineSync),
        .lineRise(lineRise),
        .bitStrobe(bitStrobe),
        .bitValue(bitValue),
        .bitError(bitError),
        .gapReached(gapReached)
    );
    assign frameEnd = regCtrlRun && (state == RX_RECEIVE || state == RX_FORWARD) && gapReached;
    always_comb begin
        nextState = state;
        if (!regCtrlRun) nextState = RX_WAIT_GAP;
        else if (state == RX_WAIT_GAP) nextState = gapReached ? RX_IDLE : state;
        else if (state == RX_IDLE) nextState = lineRise ? RX_RECEIVE : state;
        else if (gapReached) nextState = RX_IDLE;
        else if (state == RX_RECEIVE && pixelPending && regCtrlForward) nextState = RX_FORWARD;
    end
    always_ff @(posedge clk6_4mhz or posedge reset) begin
        if (reset) begin
            state <= RX_WAIT_GAP;
            shiftReg <= '0;
            bitCount <= '0;
            pixelPending <= 1'b0;
            frameCount <= '0;
            pixelData <= '0;
            pixelValid <= 1'b0;
            pixelIndex <= '0;
            pixelCount <= '0;
            frameDone <= 1'b0;
            errHigh <= 1'b0;
            errPartial <= 1'b0;
            errOverflow <= 1'b0;
            streamForward <= 1'b0;
        end else begin
            state <= nextState;
            pixelValid <= 1'b0;
            frameDone <= 1'b0;
            errHigh <= 1'b0;
            errPartial <= 1'b0;
            errOverflow <= 1'b0;
            pixelPending <= 1'b0;
            streamForward <= regCtrlRun && state == RX_FORWARD && !gapReached && lineSync;
            // a completed pixel is committed the cycle after its 24th bit, whatever the state
            if (pixelPending) begin
                if (frameCount > LAST_INDEX) errOverflow <= 1'b1;
                else begin
                    pixelData <= shiftReg;
                    pixelIndex <= frameCount[BUFFER_BITS-1:0];
                    pixelValid <= 1'b1;
                    frameCount <= frameCount + ONE_PIXEL;
                end
            end
            if (!regCtrlRun) bitCount <= '0;
            else if (state == RX_IDLE && lineRise) begin
                frameCount <= '0;
                pixelIndex <= '0;
            end else if (frameEnd) begin
                frameDone <= 1'b1;
                pixelCount <= frameCount;
                errPartial <= bitCount != 5'd0;
                bitCount <= '0;
            end else if (state == RX_RECEIVE && bitStrobe) begin
                if (bitError) errHigh <= 1'b1;
                else begin
                    shiftReg <= {shiftReg[22:0], bitValue};
                    bitCount <= bitCount == 5'd23 ? 5'd0 : bitCount + 5'd1;
                    pixelPending <= bitCount == 5'd23;
                end
            end
        end
    end
endmodule

// File: tb/tb_anton_neopixel_stream_receiver.sv
// tb_anton_neopixel_stream_receiver: table, hand-written and randomized frames against a pixel-level model
module tb_anton_neopixel_stream_receiver;
    localparam int BE = 3;
    localparam int RD = 16;
    localparam int NCYC = 100000;
    logic clk = 1'b0;
    logic reset, run, fwdMode, streamIn;
    logic streamForward, pixelValid, frameDone, errHigh, errPartial, errOverflow;
    logic [23:0] pixelData;
    logic [1:0] pixelIndex;
    logic [2:0] pixelCount;
    int checks = 0, errors = 0;
    int cyc = 0;
    bit pinAt[NCYC];
    bit fwdAt[NCYC];
    logic [23:0] gotData[$];
    int gotIdx[$];
    int nDone = 0, nHigh = 0, nPart = 0, nOvf = 0;
    logic [23:0] tablePix[5] = '{24'hFF0000, 24'h00FF00, 24'hA5C33C, 24'h123456, 24'hFEDCBA};
    typedef struct {
        string name;
        int nPix;
        bit fwd;
        int extraBits;
        int expValid;
        int expCount;
        int expOvf;
        int expPart;
    } vec_t;
    vec_t vecs[4];
    anton_neopixel_stream_receiver #(.BUFFER_END(BE), .RESET_DELAY(RD)) dut (
        .clk6_4mhz(clk),
        .reset(reset),
        .regCtrlRun(run),
        .regCtrlForward(fwdMode),
        .streamIn(streamIn),
        .streamForward(streamForward),
        .pixelData(pixelData),
        .pixelValid(pixelValid),
        .pixelIndex(pixelIndex),
        .pixelCount(pixelCount),
        .frameDone(frameDone),
        .errHigh(errHigh),
        .errPartial(errPartial),
        .errOverflow(errOverflow)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (cyc < NCYC) pinAt[cyc] <= streamIn;
        cyc <= cyc + 1;
    end
    always @(negedge clk) begin
        if (cyc > 0 && cyc <= NCYC) fwdAt[cyc-1] = streamForward;
        if (pixelValid) begin
            gotData.push_back(pixelData);
            gotIdx.push_back(int'(pixelIndex));
        end
        nDone += int'(frameDone);
        nHigh += int'(errHigh);
        nPart += int'(errPartial);
        nOvf += int'(errOverflow);
    end
    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask
    task automatic sendPulse(int hi, int lo);
        streamIn = 1'b1;
        repeat (hi) @(negedge clk);
        streamIn = 1'b0;
        repeat (lo) @(negedge clk);
    endtask
    task automatic sendBit(bit b, bit jitter);
        int hi, lo;
        if (jitter) begin
            hi = b ? int'($urandom_range(6, 4)) : int'($urandom_range(3, 1));
            lo = 8 - hi + int'($urandom_range(2, 0)) - 1;
            if (lo < 2) lo = 2;
        end else begin
            hi = b ? 5 : 2;
            lo = b ? 3 : 6;
        end
        sendPulse(hi, lo);
    endtask
    task automatic sendPixel(logic [23:0] p, bit jitter);
        for (int i = 23; i >= 0; i--) sendBit(p[i], jitter);
    endtask
    task automatic sendGap();
        streamIn = 1'b0;
        repeat (RD + 10) @(negedge clk);
    endtask
    task automatic checkFrame(string tag, logic [23:0] expPix[$], int expCount, int expOvf,
                              int expPart, int expHigh, int expDone);
        logic [2:0] pc;
        @(negedge clk);
        pc = pixelCount;
        @(posedge clk);
        chk({tag, "_nvalid"}, 64'(gotData.size()), 64'(expPix.size()));
        for (int i = 0; i < gotData.size() && i < expPix.size(); i++) begin
            chk({tag, "_data"}, 64'(gotData[i]), 64'(expPix[i]));
            chk({tag, "_index"}, 64'(gotIdx[i]), 64'(i));
        end
        chk({tag, "_count"}, 64'(pc), 64'(expCount));
        chk({tag, "_done"}, 64'(nDone), 64'(expDone));
        chk({tag, "_ovf"}, 64'(nOvf), 64'(expOvf));
        chk({tag, "_partial"}, 64'(nPart), 64'(expPart));
        chk({tag, "_high"}, 64'(nHigh), 64'(expHigh));
        gotData.delete();
        gotIdx.delete();
        nDone = 0;
        nHigh = 0;
        nPart = 0;
        nOvf = 0;
        @(negedge clk);
    endtask
    initial begin
        logic [23:0] exp[$];
        logic [23:0] pix[$];
        int frameStart, cycStart, cycEnd, mism, ones, expOnes, n, extra;
        bit fwd;
        vecs[0] = '{"three", 3, 1'b0, 0, 3, 3, 0, 0};
        vecs[1] = '{"forward", 3, 1'b1, 0, 1, 1, 0, 0};
        vecs[2] = '{"partial", 0, 1'b0, 12, 0, 0, 0, 1};
        vecs[3] = '{"overflow", 5, 1'b0, 0, 4, 4, 1, 0};
        reset = 1'b1;
        run = 1'b1;
        fwdMode = 1'b0;
        streamIn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", 64'(pixelData), 64'd0);
        chk("rst_flags", 64'({pixelValid, frameDone, errHigh, errPartial, errOverflow, streamForward}), 64'd0);
        chk("rst_index", 64'(pixelIndex), 64'd0);
        chk("rst_count", 64'(pixelCount), 64'd0);
        reset = 1'b0;
        sendGap();
        for (int v = 0; v < 4; v++) begin
            fwdMode = vecs[v].fwd;
            frameStart = cyc;
            cycStart = cyc;
            for (int i = 0; i < vecs[v].nPix; i++) begin
                if (i == 1) cycStart = cyc;
                sendPixel(tablePix[i], 1'b0);
            end
            cycEnd = cyc;
            for (int i = 0; i < vecs[v].extraBits; i++) sendBit(1'($urandom), 1'b0);
            sendGap();
            exp.delete();
            for (int i = 0; i < vecs[v].expValid; i++) exp.push_back(tablePix[i]);
            checkFrame(vecs[v].name, exp, vecs[v].expCount, vecs[v].expOvf, vecs[v].expPart, 0, 1);
            if (vecs[v].fwd) begin
                mism = 0;
                ones = 0;
                for (int c = frameStart; c < cycEnd; c++) begin
                    if (fwdAt[c+2] != (c >= cycStart ? pinAt[c] : 1'b0)) mism++;
                    ones += int'(fwdAt[c+2]);
                end
                expOnes = 0;
                for (int i = 1; i < vecs[v].nPix; i++)
                    expOnes += 5 * $countones(tablePix[i]) + 2 * (24 - $countones(tablePix[i]));
                chk("fwd_wave_mismatches", 64'(mism), 64'd0);
                chk("fwd_high_ticks", 64'(ones), 64'(expOnes));
            end
        end
        fwdMode = 1'b0;
        sendPulse(10, 4);
        sendPixel(24'h5A5A5A, 1'b0);
        sendGap();
        checkFrame("long_high", '{24'h5A5A5A}, 1, 0, 0, 1, 1);
        sendPixel(24'h0F0F0F, 1'b0);
        for (int i = 23; i > 13; i--) sendBit(tablePix[1][i], 1'b0);
        streamIn = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sendPulse(2, 3);
        for (int i = 12; i >= 0; i--) sendBit(tablePix[1][i], 1'b0);
        sendPixel(tablePix[2], 1'b0);
        sendGap();
        checkFrame("mid_reset", '{24'h0F0F0F}, 0, 0, 0, 0, 0);
        sendPixel(24'hC0FFEE, 1'b0);
        sendPixel(24'h000001, 1'b0);
        sendGap();
        checkFrame("after_reset", '{24'hC0FFEE, 24'h000001}, 2, 0, 0, 0, 1);
        sendPixel(24'h808080, 1'b0);
        for (int i = 0; i < 8; i++) sendBit(1'b1, 1'b0);
        run = 1'b0;
        repeat (5) @(negedge clk);
        run = 1'b1;
        sendGap();
        checkFrame("run_off", '{24'h808080}, 2, 0, 0, 0, 0);
        for (int f = 0; f < 12; f++) begin
            n = int'($urandom_range(5, 1));
            fwd = ($urandom_range(3, 0) == 0);
            extra = ($urandom_range(2, 0) == 0) ? int'($urandom_range(23, 1)) : 0;
            fwdMode = fwd;
            pix.delete();
            for (int i = 0; i < n; i++) pix.push_back(24'($urandom));
            foreach (pix[i]) sendPixel(pix[i], 1'b1);
            for (int i = 0; i < extra; i++) sendBit(1'($urandom), 1'b1);
            sendGap();
            exp.delete();
            for (int i = 0; i < (fwd ? 1 : (n < BE + 1 ? n : BE + 1)); i++) exp.push_back(pix[i]);
            checkFrame("random", exp, exp.size(), fwd ? 0 : (n > BE + 1 ? n - BE - 1 : 0),
                       (!fwd && extra != 0) ? 1 : 0, 0, 1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
